// File: rtl/dm_ws.sv
// Byte-addressable big-endian data memory with byte/half/word access, sign/zero extension,
// misalignment and range checking, and a programmable number of wait states per access.
module dm_ws #(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [7:0]  mem [DEPTH_BYTES];

    logic [32:0]   nbytes;
    logic [32:0]   last_byte;
    logic          acc_err;
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]    b0, b1, b2, b3;
    logic          ext;
    logic [31:0]   load_data;
    logic          fire;
    logic          do_write;

    always_comb begin
        nbytes = 33'd4;
        unique case (size_q)
            2'b00:   nbytes = 33'd1;
            2'b01:   nbytes = 33'd2;
            default: nbytes = 33'd4;
        endcase
        // 33-bit sum so an address near 2^32 cannot wrap back into range
        last_byte = {1'b0, addr_q} + nbytes - 33'd1;
        acc_err   = (size_q == 2'b11)
                  || (size_q == 2'b01 && addr_q[0])
                  || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
                  || (last_byte >= 33'(DEPTH_BYTES));

        idx0 = addr_q[AW-1:0];
        idx1 = idx0 + AW'(1);
        idx2 = idx0 + AW'(2);
        idx3 = idx0 + AW'(3);
        b0   = mem[idx0];
        b1   = mem[idx1];
        b2   = mem[idx2];
        b3   = mem[idx3];

        ext       = ~uns_q & b0[7];
        load_data = {b0, b1, b2, b3};
        unique case (size_q)
            2'b00:   load_data = {{24{ext}}, b0};
            2'b01:   load_data = {{16{ext}}, b0, b1};
            default: load_data = {b0, b1, b2, b3};
        endcase

        fire     = (state_q == StBusy) && (cnt_q == 4'd0);
        do_write = fire && we_q && !acc_err;
    end

    // Storage is deliberately not reset; a reset mid-access drops the write via state_q.
    always_ff @(posedge clk) begin
        if (do_write) begin
            unique case (size_q)
                2'b00: mem[idx0] <= wdata_q[7:0];
                2'b01: begin
                    mem[idx0] <= wdata_q[15:8];
                    mem[idx1] <= wdata_q[7:0];
                end
                default: begin
                    mem[idx0] <= wdata_q[31:24];
                    mem[idx1] <= wdata_q[23:16];
                    mem[idx2] <= wdata_q[15:8];
                    mem[idx3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        done_q  <= 1'b1;
                        err_q   <= acc_err;
                        rdata_q <= (acc_err || we_q) ? 32'd0 : load_data;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_ws.sv
// Scoreboard bench for dm_ws: three instances (128B/0 waits, 128B/3 waits, 64B/0 waits)
// checked against a byte-array reference model of the memory.
module tb_dm_ws;

    localparam int DEP [3] = '{128, 128, 64};
    localparam int WT  [3] = '{0, 3, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_v;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ready_v, done_v, err_v;
    logic [31:0] rdata_v [3];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int        sel;
        bit        err;
        bit [31:0] rdata;
    } exp_t;

    exp_t     sb_q[$];
    bit [7:0] mm [3][128];

    always #5 clk = ~clk;

    dm_ws #(.DEPTH_BYTES(128), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready_v[0]), .done(done_v[0]), .err(err_v[0]),
        .rdata(rdata_v[0])
    );
    dm_ws #(.DEPTH_BYTES(128), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready_v[1]), .done(done_v[1]), .err(err_v[1]),
        .rdata(rdata_v[1])
    );
    dm_ws #(.DEPTH_BYTES(64), .WAIT_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready_v[2]), .done(done_v[2]), .err(err_v[2]),
        .rdata(rdata_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: access width in bytes, alignment, range, big-endian byte order.
    function automatic void model(input int s, input bit w, input bit [1:0] sz, input bit u,
                                  input bit [31:0] a, input bit [31:0] wd,
                                  output bit e, output bit [31:0] rd);
        int        n;
        longint    last;
        bit [31:0] v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = longint'(a) + longint'(n) - 1;
        e    = (sz == 2'd3) || ((a % 32'(n)) != 0) || (last >= longint'(DEP[s]));
        rd   = 32'd0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < n; i++) mm[s][a + i] = 8'(wd >> (8 * (n - 1 - i)));
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[s][a + i]);
            if (n < 4 && !u && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    if (sb_q.size() == 0 || sb_q[0].sel != i) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done dut=%0d got done=1 expected none", i);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check($sformatf("err dut=%0d", i), 32'(err_v[i]), 32'(e.err));
                        check($sformatf("rdata dut=%0d", i), rdata_v[i], e.rdata);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle so calls chain back-to-back.
    task automatic do_op(input int s, input bit w, input bit [1:0] sz, input bit u,
                         input bit [31:0] a, input bit [31:0] wd, input bit hold);
        exp_t e;
        int   guard;
        int   lat;
        bit   seen;
        guard = 0;
        while (!ready_v[s] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("ready_before_req dut=%0d", s), 32'(ready_v[s]), 32'd1);
        we    = w;
        size  = sz;
        uns   = u;
        addr  = a;
        wdata = wd;
        model(s, w, sz, u, a, wd, e.err, e.rdata);
        e.sel = s;
        sb_q.push_back(e);
        req_v[s] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_v[s] = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat <= 40) begin
            @(negedge clk);
            if (done_v[s]) seen = 1'b1;
            else begin
                if (ready_v[s]) check($sformatf("ready_busy dut=%0d", s), 32'd1, 32'd0);
                lat++;
            end
        end
        req_v[s] = 1'b0;
        check($sformatf("latency dut=%0d", s), seen ? lat : -1, WT[s] + 1);
        if (seen) check($sformatf("ready_in_done dut=%0d", s), 32'(ready_v[s]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [1:0]  sz;
        bit [31:0] a;
        int        r;
        int        n;
        rst_n = 1'b0;
        req_v = 3'b000;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready dut=%0d", i), 32'(ready_v[i]), 32'd1);
            check($sformatf("rst_done dut=%0d", i), 32'(done_v[i]), 32'd0);
            check($sformatf("rst_err dut=%0d", i), 32'(err_v[i]), 32'd0);
            check($sformatf("rst_rdata dut=%0d", i), rdata_v[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Bring every byte to a known value.
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < DEP[s]; i += 4) do_op(s, 1, 2'd2, 0, 32'(i), $urandom, 0);

        // Word round trip, partial stores, errors.
        do_op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        do_op(0, 0, 2'd2, 0, 32'h10, 32'd0, 0);
        do_op(0, 0, 2'd0, 0, 32'h10, 32'd0, 0);
        do_op(0, 0, 2'd0, 1, 32'h13, 32'd0, 0);
        do_op(0, 0, 2'd1, 0, 32'h12, 32'd0, 0);
        do_op(0, 1, 2'd0, 0, 32'h11, 32'h000000A5, 0);
        do_op(0, 0, 2'd2, 0, 32'h10, 32'd0, 0);
        do_op(0, 1, 2'd1, 0, 32'h12, 32'h00001234, 0);
        do_op(0, 0, 2'd2, 0, 32'h10, 32'd0, 0);
        do_op(0, 0, 2'd2, 0, 32'h02, 32'd0, 0);
        do_op(0, 1, 2'd1, 0, 32'h05, 32'hFFFF, 0);
        do_op(0, 0, 2'd2, 0, 32'h04, 32'd0, 0);
        do_op(0, 1, 2'd2, 0, 32'h7C, 32'hCAFEF00D, 0);
        do_op(0, 0, 2'd2, 0, 32'h7C, 32'd0, 0);
        do_op(0, 1, 2'd2, 0, 32'h80, 32'h12345678, 0);
        do_op(0, 0, 2'd3, 0, 32'h10, 32'd0, 0);
        do_op(0, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'd0, 0);

        // Wait states: plain, req held through busy, back-to-back.
        do_op(1, 1, 2'd2, 0, 32'h40, 32'hA1B2C3D4, 0);
        do_op(1, 0, 2'd2, 0, 32'h40, 32'd0, 1);
        do_op(1, 0, 2'd0, 0, 32'h42, 32'd0, 0);
        do_op(1, 0, 2'd1, 1, 32'h40, 32'd0, 0);

        // Reset during a pending store: nothing written, no done.
        we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h20; wdata = 32'h11223344;
        req_v[1] = 1'b1;
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready_v[1]), 32'd1);
        check("abort_done", 32'(done_v[1]), 32'd0);
        check("abort_rdata", rdata_v[1], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_op(1, 0, 2'd2, 0, 32'h20, 32'd0, 0);

        // Boundary on the 64-byte instance.
        do_op(2, 0, 2'd0, 1, 32'h3F, 32'd0, 0);
        do_op(2, 0, 2'd1, 0, 32'h3F, 32'd0, 0);
        do_op(2, 0, 2'd1, 0, 32'h3E, 32'd0, 0);
        do_op(2, 0, 2'd0, 0, 32'h40, 32'd0, 0);

        // Randomised traffic.
        for (int k = 0; k < 450; k++) begin
            int s;
            s  = k % 3;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            r  = $urandom_range(0, 19);
            if (r == 0)      a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else if (r == 1) a = $urandom;
            else             a = 32'($urandom_range(0, DEP[s] + 3));
            if (r >= 2 && r < 16) a = a & ~32'(n - 1);
            do_op(s, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
